// File: rtl/fifo_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_uart_pkg
// Description : Shared constants and FSM state encoding for the FIFO-fed
//               UART transmitter. The PARITY state exists only when
//               FIFO_UART_TX_PARITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_uart_pkg;

    // 100 MHz system clock, 115200 baud
    localparam int unsigned c_default_clks_per_bit = 868;
    localparam int unsigned c_default_data_w       = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
`ifdef FIFO_UART_TX_PARITY_EN
        PARITY = 3'd4,
`endif
        STOP   = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/fifo_uart_baud.sv
`default_nettype none
// ============================================================================
// Module      : fifo_uart_baud
// Description : Bit-period counter. Counts 0..CLKS_PER_BIT-1 and emits a
//               one-cycle bit_tick on the last cycle of every bit period.
//               A synchronous restart holds the counter at zero so the next
//               bit period starts cleanly.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_uart_baud
    import fifo_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = c_default_clks_per_bit
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic bit_tick
);

    localparam int unsigned              c_cnt_w   = $clog2(CLKS_PER_BIT);
    localparam logic [c_cnt_w-1:0]       c_cnt_max = c_cnt_w'(CLKS_PER_BIT - 1);

    logic [c_cnt_w-1:0] r_cnt;

    // Bit-period counter: wraps at the bit boundary, zeroed by restart
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (restart || (r_cnt == c_cnt_max)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign bit_tick = !restart && (r_cnt == c_cnt_max);

endmodule
`default_nettype wire

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : fifo_uart_tx
// Description : UART transmitter that pulls bytes from an upstream FIFO
//               (one read per frame, data valid the cycle after the read
//               strobe) and serialises them LSB first: start, data,
//               optional even parity, stop.
//               Optional feature macro: FIFO_UART_TX_PARITY_EN
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = c_default_clks_per_bit,
    parameter int unsigned DATA_W       = c_default_data_w
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              fifo_rd_en,
    output logic              tx,
    output logic              busy,
    output logic              frame_done
);

    localparam int unsigned          c_bit_w    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [c_bit_w-1:0]   c_last_bit = c_bit_w'(DATA_W - 1);

    state_t              r_state;
    state_t              w_next;
    logic [DATA_W-1:0]   r_shift;
    logic [c_bit_w-1:0]  r_bit_cnt;
    logic                w_bit_tick;
    logic                w_restart;
    logic                w_rd_en;
    logic                w_tx;
    logic                w_frame_done;
    logic                w_load;
    logic                w_shift;
`ifdef FIFO_UART_TX_PARITY_EN
    logic                r_parity;
`endif

    fifo_uart_baud #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .reset    (reset),
        .restart  (w_restart),
        .bit_tick (w_bit_tick)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and per-state line level / strobes
    always_comb begin
        w_next       = r_state;
        w_rd_en      = 1'b0;
        w_tx         = 1'b1;
        w_frame_done = 1'b0;
        w_restart    = 1'b0;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        case (r_state)
            IDLE: begin
                w_restart = 1'b1;
                if (!fifo_empty) begin
                    w_rd_en = 1'b1;
                    w_next  = FETCH;
                end
            end
            FETCH: begin
                // Read data is valid now; baud counter held so START gets a full bit
                w_restart = 1'b1;
                w_load    = 1'b1;
                w_next    = START;
            end
            START: begin
                w_tx = 1'b0;
                if (w_bit_tick) begin
                    w_next = DATA;
                end
            end
            DATA: begin
                w_tx = r_shift[0];
                if (w_bit_tick) begin
                    w_shift = 1'b1;
                    if (r_bit_cnt == c_last_bit) begin
`ifdef FIFO_UART_TX_PARITY_EN
                        w_next = PARITY;
`else
                        w_next = STOP;
`endif
                    end
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY: begin
                w_tx = r_parity;
                if (w_bit_tick) begin
                    w_next = STOP;
                end
            end
`endif
            STOP: begin
                w_tx = 1'b1;
                if (w_bit_tick) begin
                    w_frame_done = 1'b1;
                    w_next       = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Shift register, bit counter and parity: loaded in FETCH, shifted per data bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else if (w_load) begin
            r_shift   <= fifo_dout;
            r_bit_cnt <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
            r_parity  <= ^fifo_dout;
`endif
        end else if (w_shift) begin
            r_shift   <= r_shift >> 1;
            r_bit_cnt <= r_bit_cnt + 1'b1;
        end
    end

    // Reset forces the state to IDLE asynchronously; the strobe is also gated
    // so a non-empty FIFO cannot raise it while reset is held.
    assign fifo_rd_en = w_rd_en & ~reset;
    assign tx         = w_tx;
    assign frame_done = w_frame_done;
    assign busy       = (r_state != IDLE) | fifo_rd_en;

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_uart_tx
// Description : Self-checking bench for fifo_uart_tx. A FIFO model feeds the
//               DUT, a scoreboard queue holds the bytes expected on the line
//               and a serial monitor decodes frames and compares them.
//               A second instance at CLKS_PER_BIT=2 checks frame length.
//               Honours FIFO_UART_TX_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_uart_tx;

    localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       fifo_empty;
    logic [7:0] fifo_dout = 8'h00;
    logic       fifo_rd_en, tx, busy, frame_done;

    // Second instance, CLKS_PER_BIT = 2
    logic       empty2;
    logic [7:0] dout2 = 8'hC3;
    logic       rd_en2, tx2, busy2, frame_done2;

    always #5 clk = ~clk;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_W(8)) dut (
        .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
        .fifo_rd_en(fifo_rd_en), .tx(tx), .busy(busy), .frame_done(frame_done));

    fifo_uart_tx #(.CLKS_PER_BIT(2), .DATA_W(8)) dut2 (
        .clk(clk), .reset(reset), .fifo_empty(empty2), .fifo_dout(dout2),
        .fifo_rd_en(rd_en2), .tx(tx2), .busy(busy2), .frame_done(frame_done2));

    // ---------------- FIFO models ----------------
    logic [7:0] mem [0:31];
    logic [5:0] wr_ptr = '0;
    logic [5:0] rd_ptr = '0;
    logic       gate   = 1'b0;
    assign fifo_empty = gate | (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en && !fifo_empty) begin
            fifo_dout <= mem[rd_ptr[4:0]];
            rd_ptr    <= rd_ptr + 6'd1;
        end
    end

    logic [3:0] w2 = '0;
    logic [3:0] r2 = '0;
    assign empty2 = (w2 == r2);
    always @(posedge clk) begin
        if (rd_en2 && !empty2) r2 <= r2 + 4'd1;
    end

    // ---------------- bookkeeping ----------------
    int n_vec = 0, n_err = 0;
    int cyc = 0, n_rd = 0, n_viol = 0, n_frames = 0, n_abort = 0, n_gap = 0;
    int done_cyc = 0, s2 = 0, len2 = 0;
    logic have_done = 1'b0, done_btb = 1'b0, in2 = 1'b0;
    logic [7:0] exp_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (fifo_rd_en) n_rd = n_rd + 1;
        if (fifo_rd_en && fifo_empty) n_viol = n_viol + 1;
    end

    // Frame length of the fast instance: first start-bit cycle through frame_done
    always @(negedge clk) begin
        if (reset) begin
            in2 = 1'b0;
        end else begin
            if (!in2 && !tx2) begin
                in2 = 1'b1;
                s2  = cyc;
            end
            if (frame_done2) begin
                len2 = cyc - s2 + 1;
                in2  = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr[4:0]] = b;
        wr_ptr = wr_ptr + 6'd1;
        exp_q.push_back(b);
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k = 0;
        while (n_frames < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("frames_in_time", 32'(n_frames >= n), 32'd1);
    endtask

    // ---------------- serial monitor / scoreboard pop ----------------
    initial begin : frame_mon
        logic [7:0]  d;
        logic [10:0] want, got;
        logic        bitval, stable, aborted, fd_last;
        int          fd_cnt, start_cyc;
        forever begin
            @(negedge clk);
            if (reset !== 1'b0 || tx !== 1'b0) continue;
            start_cyc = cyc;
            if (have_done && done_btb) begin
                n_gap++;
                check("gap", 32'(start_cyc - done_cyc), 32'd3);
            end
            have_done = 1'b0;
            check("frame_expected", 32'(exp_q.size() > 0), 32'd1);
            d = 8'h00;
            if (exp_q.size() > 0) d = exp_q.pop_front();
            want = '0;
`ifdef FIFO_UART_TX_PARITY_EN
            want = {1'b1, ^d, d, 1'b0};
`else
            want[9:0] = {1'b1, d, 1'b0};
`endif
            got = '0; stable = 1'b1; aborted = 1'b0; fd_cnt = 0; fd_last = 1'b0; bitval = 1'b0;
            for (int b = 0; b < NB && !aborted; b++) begin
                for (int c = 0; c < CPB && !aborted; c++) begin
                    if (b != 0 || c != 0) @(negedge clk);
                    if (reset) begin
                        aborted = 1'b1;
                    end else begin
                        if (c == 0) bitval = tx;
                        else if (tx !== bitval) stable = 1'b0;
                        got[b] = bitval;
                        if (frame_done) begin
                            fd_cnt++;
                            if (b == NB-1 && c == CPB-1) fd_last = 1'b1;
                        end
                    end
                end
            end
            if (aborted) begin
                n_abort++;
                continue;
            end
            check("frame_bits", 32'(got), 32'(want));
            check("bit_stable", 32'(stable), 32'd1);
            check("frame_done_pulse", {30'd0, (fd_cnt == 1), fd_last}, 32'd3);
            done_cyc = cyc;
            @(negedge clk);
            if (!reset) begin
                done_btb = !fifo_empty;
                check("next_strobe", 32'(fifo_rd_en), 32'(done_btb));
                have_done = 1'b1;
            end
            n_frames++;
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin : stim
        logic ok;
        logic [7:0] batch [16];
        batch = '{8'd45, 8'd73, 8'd34, 8'd94, 8'd5, 8'd23, 8'd87, 8'd72,
                  8'd11, 8'd41, 8'd66, 8'd21, 8'd88, 8'd50, 8'd28, 8'd32};
        reset = 1'b1;

        // Reset state, then 100 idle cycles with the FIFO empty
        @(posedge clk); #1;
        check("reset_outputs", {28'd0, tx, busy, fifo_rd_en, frame_done}, 32'h8);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        ok = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if ({tx, busy, fifo_rd_en} !== 3'b100) ok = 1'b0;
        end
        check("idle_100", 32'(ok), 32'd1);

        // Single byte 0x2D, plus one byte into the fast instance
        @(posedge clk); #1;
        push(8'd45);
        w2 = w2 + 4'd1;
        wait_frames(1, 200);
        check("rd_single", n_rd, 1);
        check("frames_single", n_frames, 1);
        check("len_cpb2", len2, NB * 2);

        // Sixteen bytes back-to-back
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) push(batch[i]);
        wait_frames(17, 2000);
        check("rd_batch", n_rd, 17);
        check("frames_batch", n_frames, 17);
        check("gap_count", n_gap, 15);

        // Reset in the middle of the data bits of 73; 34 must follow intact
        @(posedge clk); #1;
        push(8'd73);
        push(8'd34);
        repeat (16) @(posedge clk);
        #1 reset = 1'b1;
        #1 check("reset_async", {28'd0, tx, busy, fifo_rd_en, frame_done}, 32'h8);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        wait_frames(18, 300);
        check("abort_count", n_abort, 1);
        check("rd_after_reset", n_rd, 19);
        check("frames_after_reset", n_frames, 18);

        // fifo_empty flickering every 3 cycles
        @(posedge clk); #1;
        gate = 1'b1;
        push(8'hA5); push(8'h3C); push(8'hFF); push(8'h00);
        for (int i = 0; i < 1500 && n_frames < 22; i++) begin
            @(posedge clk); #1;
            if (i % 3 == 2) gate = ~gate;
        end
        gate = 1'b0;
        repeat (4) @(negedge clk);
        check("frames_toggle", n_frames, 22);
        check("rd_toggle", n_rd, 23);
        check("rd_while_empty", n_viol, 0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clock cycles per serial bit (100 MHz / 115200 baud); legal range 2..65535.
REQ-002 Parameter DATA_W, default 8, data bits per frame; SHALL match the upstream FIFO data width.
REQ-003 clk  input  1  system clock, all logic on posedge; one clock domain only.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 fifo_empty  input  1  upstream FIFO empty flag.
REQ-006 fifo_dout  input  DATA_W  upstream FIFO read data, valid the cycle after fifo_rd_en is asserted.
REQ-007 fifo_rd_en  output  1  single-cycle read strobe to the upstream FIFO.
REQ-008 tx  output  1  serial line, idle high.
REQ-009 busy  output  1  high from the read strobe until the end of the stop bit.
REQ-010 frame_done  output  1  one-cycle pulse on the last cycle of the stop bit.

Function
REQ-011 The FSM SHALL have states IDLE, FETCH, START, DATA, PARITY, STOP.
REQ-012 IDLE with fifo_empty=0: assert fifo_rd_en for exactly one cycle and go to FETCH; with fifo_empty=1, remain in IDLE with fifo_rd_en=0.
REQ-013 FETCH lasts one cycle: capture fifo_dout into the shift register, clear the bit counter, go to START.
REQ-014 START: drive tx=0 for CLKS_PER_BIT cycles, then go to DATA.
REQ-015 DATA: send DATA_W bits LSB first, each held CLKS_PER_BIT cycles; after bit DATA_W-1, go to PARITY (if enabled) or STOP.
REQ-016 STOP: drive tx=1 for CLKS_PER_BIT cycles, pulse frame_done on the final cycle, then go to IDLE.
REQ-017 Back-to-back: if fifo_empty=0 on the cycle STOP exits, the IDLE→FETCH strobe SHALL be issued on the very next cycle; inter-frame gap is exactly 2 clk cycles of tx=1 beyond the stop bit.
REQ-018 fifo_rd_en SHALL never be asserted while fifo_empty=1 or outside IDLE; at most one read per frame.
REQ-019 fifo_empty rising mid-frame SHALL NOT affect the frame in progress.
REQ-020 The baud counter width SHALL be clog2(CLKS_PER_BIT); the counter counts 0..CLKS_PER_BIT-1 and wraps on each bit boundary.
REQ-021 busy=1 in FETCH, START, DATA, PARITY and STOP, and on the IDLE cycle where fifo_rd_en=1.

Reset
REQ-022 reset=1 SHALL immediately force IDLE, tx=1, busy=0, fifo_rd_en=0, frame_done=0, and clear all counters and the shift register.
REQ-023 Reset mid-frame SHALL abort the frame; the byte is lost and no retry is made; operation resumes from IDLE on the first posedge after reset deasserts.

Configuration
REQ-024 Macro FIFO_UART_TX_PARITY_EN defined: PARITY state inserted after DATA, sending an even-parity bit (XOR of the data bits) for CLKS_PER_BIT cycles.
REQ-025 Macro undefined: PARITY state and parity logic absent; DATA goes directly to STOP; frame = 10 bit-times for DATA_W=8.

Structure
REQ-026 Package fifo_uart_pkg SHALL hold the state encoding constants, the default CLKS_PER_BIT and DATA_W.
REQ-027 Sub-module fifo_uart_baud SHALL hold the bit-period counter, producing a one-cycle bit_tick and accepting a synchronous restart input.

Verification
REQ-028 Reset with the FIFO empty, CLKS_PER_BIT=4 → tx=1, busy=0, fifo_rd_en=0 held for 100 cycles.
REQ-029 FIFO holds 8'd45 (0x2D) → one rd_en pulse; tx sequence 0,1,0,1,1,0,1,0,0,1 at 4 clk per bit; frame_done once; with parity enabled, parity bit 0 precedes the stop bit.
REQ-030 FIFO preloaded with 16 bytes (45,73,34,94,5,23,87,72,11,41,66,21,88,50,28,32) → 16 frames decoded in order, 16 rd_en pulses, gaps exactly 2 cycles.
REQ-031 Assert reset mid-DATA of byte 73 → tx=1 within 0 cycles (async); after release, the next FIFO byte is sent in full and byte 73 is never emitted.
REQ-032 fifo_empty toggled 1/0 every 3 cycles → no rd_en while empty, no frame corruption, every byte read is sent exactly once.
REQ-033 CLKS_PER_BIT=2 → frame length 20 cycles (22 with parity), measured from the start-bit edge to the rising edge of frame_done+1.
